// File: rtl/bus_arbiter_pkg.sv
// Shared constants for the two-master serial bus arbiter: state encoding,
// default widths and slave-ID values used by master and slave ports.
package bus_pkg;

    localparam int SLAVE_ID_BITS_DEF = 2;
    localparam int NUM_SLAVES_DEF    = 3;

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_SSEL    = 2'd1;
    localparam logic [1:0] ST_ACTIVE  = 2'd2;
    localparam logic [1:0] ST_RELEASE = 2'd3;

    localparam logic [SLAVE_ID_BITS_DEF-1:0] SLAVE_0 = 2'd0;
    localparam logic [SLAVE_ID_BITS_DEF-1:0] SLAVE_1 = 2'd1;
    localparam logic [SLAVE_ID_BITS_DEF-1:0] SLAVE_2 = 2'd2;

endpackage

// File: rtl/bus_arbiter_if.sv
// Master-side request/slave-ID lines and arbiter-side grant/enable/status lines.
import bus_pkg::*;

interface bus_arbiter_if #(
    parameter int SLAVE_ID_BITS = SLAVE_ID_BITS_DEF,
    parameter int NUM_SLAVES    = NUM_SLAVES_DEF
) ();
    logic                     m1_req;
    logic                     m2_req;
    logic                     m1_slave_sel;
    logic                     m2_slave_sel;
    logic                     m1_grant;
    logic                     m2_grant;
    logic                     owner;
    logic [SLAVE_ID_BITS-1:0] slave_sel;
    logic [NUM_SLAVES-1:0]    slave_en;
    logic                     bus_busy;
    logic                     sel_error;
    logic                     timeout;

    modport master (
        output m1_req, m2_req, m1_slave_sel, m2_slave_sel,
        input  m1_grant, m2_grant, owner, slave_sel, slave_en,
               bus_busy, sel_error, timeout
    );

    modport slave (
        input  m1_req, m2_req, m1_slave_sel, m2_slave_sel,
        output m1_grant, m2_grant, owner, slave_sel, slave_en,
               bus_busy, sel_error, timeout
    );
endinterface

// File: rtl/bus_arbiter_watchdog.sv
// Saturating ACTIVE-state cycle counter with terminal-count flag at TIMEOUT_CYCLES-1.
import bus_pkg::*;

module arb_watchdog #(
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    input  logic en,
    output logic tc
);
    localparam int CW = $clog2(TIMEOUT_CYCLES);
    localparam logic [CW-1:0] TC_VAL = CW'(TIMEOUT_CYCLES - 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en && (cnt != '1)) begin
            cnt <= cnt + CW'(1);
        end
    end

    assign tc = (cnt == TC_VAL);
endmodule

// File: rtl/bus_arbiter.sv
// Round-robin arbiter for two masters: grants the bus, shifts in the serial
// slave-ID, drives the one-hot slave enable and forces release on watchdog expiry.
//   state      | meaning
//   IDLE       | bus free, waiting for any request
//   SSEL       | master granted, shifting in slave-ID MSB first
//   ACTIVE     | transfer running, slave_en valid, watchdog counting
//   RELEASE    | one-cycle gap, grants dropped, priority handed over
import bus_pkg::*;

module bus_arbiter #(
    parameter int SLAVE_ID_BITS  = SLAVE_ID_BITS_DEF,
    parameter int NUM_SLAVES     = NUM_SLAVES_DEF,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic          clk,
    input  logic          reset,
    bus_arbiter_if.slave  bus
);
    localparam int CNT_W = (SLAVE_ID_BITS > 1) ? $clog2(SLAVE_ID_BITS) : 1;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(SLAVE_ID_BITS - 1);

    logic [1:0]               state;
    logic                     prio;
    logic [SLAVE_ID_BITS-1:0] id_shift;
    logic [CNT_W-1:0]         bit_cnt;
    logic                     own_req;
    logic                     own_sel;
    logic                     win;
    logic [SLAVE_ID_BITS:0]   id_ext;
    logic [SLAVE_ID_BITS-1:0] id_next;
    logic                     id_done;
    logic                     id_ok;
    logic                     rel;
    logic                     wd_tc;

    arb_watchdog #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_wd (
        .clk   (clk),
        .reset (reset),
        .clr   (state != ST_ACTIVE),
        .en    (state == ST_ACTIVE),
        .tc    (wd_tc)
    );

    // owner already points at the granted master from SSEL onwards
    always_comb begin
        own_req = bus.owner ? bus.m2_req : bus.m1_req;
        own_sel = bus.owner ? bus.m2_slave_sel : bus.m1_slave_sel;
        win     = (bus.m1_req && bus.m2_req) ? prio : bus.m2_req;
        id_ext  = {id_shift, own_sel};
        id_next = id_ext[SLAVE_ID_BITS-1:0];
        id_done = (bit_cnt == LAST_BIT);
        id_ok   = (int'(id_next) < NUM_SLAVES);
        rel     = 1'b0;
        if (state == ST_SSEL)
            rel = !own_req || (id_done && !id_ok);
        else if (state == ST_ACTIVE)
            rel = !own_req || wd_tc;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state         <= ST_IDLE;
            prio          <= 1'b0;
            id_shift      <= '0;
            bit_cnt       <= '0;
            bus.m1_grant  <= 1'b0;
            bus.m2_grant  <= 1'b0;
            bus.owner     <= 1'b0;
            bus.slave_sel <= '0;
            bus.slave_en  <= '0;
            bus.bus_busy  <= 1'b0;
            bus.sel_error <= 1'b0;
            bus.timeout   <= 1'b0;
        end else begin
            bus.sel_error <= 1'b0;
            bus.timeout   <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (bus.m1_req || bus.m2_req) begin
                        state        <= ST_SSEL;
                        bus.owner    <= win;
                        bus.m1_grant <= !win;
                        bus.m2_grant <= win;
                        bus.bus_busy <= 1'b1;
                        bit_cnt      <= '0;
                        id_shift     <= '0;
                    end
                end
                ST_SSEL: begin
                    if (own_req) begin
                        id_shift <= id_next;
                        bit_cnt  <= bit_cnt + CNT_W'(1);
                        if (id_done && id_ok) begin
                            state         <= ST_ACTIVE;
                            bus.slave_sel <= id_next;
                            bus.slave_en  <= NUM_SLAVES'(1) << id_next;
                        end else if (id_done) begin
                            bus.sel_error <= 1'b1;
                        end
                    end
                end
                ST_ACTIVE: begin
                    // a falling request wins over a simultaneous watchdog expiry
                    if (own_req && wd_tc)
                        bus.timeout <= 1'b1;
                end
                ST_RELEASE: begin
                    state        <= ST_IDLE;
                    bus.bus_busy <= 1'b0;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
            if (rel) begin
                state        <= ST_RELEASE;
                bus.m1_grant <= 1'b0;
                bus.m2_grant <= 1'b0;
                bus.slave_en <= '0;
                prio         <= !bus.owner;
            end
        end
    end
endmodule
